dragon_wave_scheduler: RTL and testbench
========================================

// Module: dragon_wave_scheduler
// PURPOSE
//  Owns NUM_SLOTS dragon enemy slots and time-shares a single position-update adder among them.
//  On each move_tick it runs one pass over all slots, one slot per cycle, in the order 0..N-1.
//  Per slot, the pass applies movement, board-edge death, respawn cooldown and an alive-count cap.
//  Sits between the LFSR random source and collision logic (upstream) and the VGA sprite renderer (downstream).
// PARAMETERS
//  NUM_SLOTS     4    number of dragon slots (2..8)
//  STEP          5    pixels moved per tick on each axis
//  COOLDOWN      100  move_ticks a dead slot waits before it may respawn
//  MAX_ALIVE     3    maximum simultaneously alive slots
//  X_MAX/Y_MAX   640/480  exclusive board limits; MARGIN 3 is the inclusive lower limit
//  SX_BASE/SX_RANGE  450/200  spawn x = SX_BASE + (rnd % SX_RANGE)
//  SY_BASE/SY_RANGE  160/320  spawn y = SY_BASE + ({rnd[4:0],rnd[9:5]} % SY_RANGE)
// PORTS
//  clk_22       in   1        system clock; one clock domain
//  rst          in   1        synchronous, active-low reset
//  move_tick    in   1        1-cycle strobe that starts a pass
//  rnd          in   10       free-running LFSR value, sampled in the cycle a slot is processed
//  kill         in   NUM_SLOTS  per-slot hit from collision logic, level-sampled every cycle
//  pos_x/pos_y  out  10*NUM_SLOTS  packed top-left coordinates; slot i is in bits [10i+9:10i]
//  alive        out  NUM_SLOTS  per-slot show_valid
//  spawn_pulse  out  1        1-cycle pulse when a slot respawns
//  spawn_id     out  3        index of the slot that respawned; valid with spawn_pulse
//  busy         out  1        high while a pass is in progress
// BEHAVIOUR
//  Reset, sampled at the clk_22 edge while rst==0:
//   alive=0, pos_x=pos_y=0, every cooldown=0, spawn_pulse=0, spawn_id=0, busy=0, FSM=IDLE, pending=0.
//  FSM states: IDLE, SCAN, DONE.
//   IDLE->SCAN when move_tick==1 or pending==1; idx=0; busy=1 from the next cycle.
//   SCAN processes slot idx. It moves to DONE after idx==NUM_SLOTS-1, otherwise idx increments.
//   DONE->IDLE after 1 cycle with busy=0. A pass therefore takes NUM_SLOTS+1 cycles.
//  move_tick while busy sets pending=1; a pending tick is held for one further pass, never more.
//   Further ticks while pending=1 are dropped.
//  SCAN on an alive slot:
//   nx = x - STEP. ny = y + STEP if rnd[0]==1, else y - STEP. Arithmetic is 10-bit, wrap allowed.
//   If nx<MARGIN, nx>=X_MAX, ny<MARGIN or ny>=Y_MAX: alive=0, cooldown=COOLDOWN, position unchanged.
//    A wrapped underflow reads as >=X_MAX/Y_MAX, so it is treated as death.
//   Otherwise pos takes (nx,ny).
//  SCAN on a dead slot:
//   If cooldown>0, cooldown decrements by 1.
//   Else, if the alive count at the start of this cycle is < MAX_ALIVE: respawn.
//    Respawn sets alive=1, loads pos from the spawn formulas, and pulses spawn_pulse with spawn_id=idx next cycle.
//   Else the slot stays dead with cooldown=0 and is retried on the next pass.
//  kill[i]==1 while alive[i]==1, in any state: alive[i]=0 and cooldown[i]=COOLDOWN the next cycle.
//   Kill beats movement when slot i is being scanned in the same cycle; the position stays frozen.
//   kill on a dead slot is ignored; its cooldown is not reloaded.
//  At most one respawn per cycle, so spawn_pulse never coincides for two slots.
//  Outputs are registered; alive/pos change 1 cycle after the SCAN cycle of that slot.
//  rst==0 mid-pass aborts the pass and restores all reset values; pending is cleared.
// CONFIGURATION
//  DRAGON_SCHED_STATS_EN defined:
//   Adds output kill_count[15:0], reset 0.
//   Increments once per kill-induced death; a board-edge death does not count. Saturates at 16'hFFFF.
//  Undefined: no kill_count port and no counter logic; all other behaviour is identical.
// TESTING
//  T1 reset then move_tick: slots 0,1,2 respawn on cycles 1,2,3 (spawn_id 0,1,2); slot 3 stays dead (MAX_ALIVE=3); busy high 5 cycles.
//  T2 slot0 at (100,200), rnd[0]=1, move_tick -> (95,205); rnd[0]=0 -> (95,195).
//  T3 slot0 at (7,200), move_tick -> x=2<MARGIN, alive[0]=0, cooldown=100; respawns on the 101st following pass, if under the cap.
//  T4 kill[1] pulsed in the same cycle slot1 is scanned -> alive[1]=0, pos unchanged, no movement; kill_count=1 with STATS_EN.
//  T5 move_tick held high for 3 consecutive cycles mid-pass -> exactly one extra pass follows; extra ticks are dropped.
//  T6 rst low during SCAN idx=2 -> next cycle every output equals its reset value and the FSM is IDLE.

Source files
------------

// File: rtl/dragon_wave_scheduler.sv
// -----------------------------------------------------------------------------
// dragon_wave_scheduler
//
// Owns NUM_SLOTS dragon enemy slots. On every move_tick one pass walks the
// slots 0..NUM_SLOTS-1, one slot per clock, sharing a single position-update
// datapath. For each slot the pass applies:
//   - movement (left by STEP, up/down by STEP depending on rnd[0]),
//   - death when the new position leaves the board,
//   - a respawn cooldown for dead slots,
//   - a cap on how many slots may be alive at the same time.
// Collision kills are accepted every cycle, independent of the pass.
//
// Optional feature: define DRAGON_SCHED_STATS_EN to add the kill_count output.
// It counts kill-induced deaths only and saturates at 16'hFFFF.
//
// Ports
//   clk_22       in   1            system clock
//   rst          in   1            synchronous reset, active low
//   move_tick    in   1            one-cycle strobe that starts a pass
//   rnd          in   10           LFSR value, used in the cycle a slot is scanned
//   kill         in   NUM_SLOTS    per-slot hit from collision logic
//   pos_x        out  10*NUM_SLOTS packed x; slot i in bits [10i+9:10i]
//   pos_y        out  10*NUM_SLOTS packed y; slot i in bits [10i+9:10i]
//   alive        out  NUM_SLOTS    per-slot show_valid
//   spawn_pulse  out  1            one-cycle pulse when a slot respawns
//   spawn_id     out  3            slot that respawned, valid with spawn_pulse
//   busy         out  1            high while a pass is in progress
//   kill_count   out  16           (DRAGON_SCHED_STATS_EN only) kill deaths
// -----------------------------------------------------------------------------
module dragon_wave_scheduler #(
  parameter int NUM_SLOTS = 4,
  parameter int STEP      = 5,
  parameter int COOLDOWN  = 100,
  parameter int MAX_ALIVE = 3,
  parameter int X_MAX     = 640,
  parameter int Y_MAX     = 480,
  parameter int MARGIN    = 3,
  parameter int SX_BASE   = 450,
  parameter int SX_RANGE  = 200,
  parameter int SY_BASE   = 160,
  parameter int SY_RANGE  = 320
) (
  input  logic                   clk_22,
  input  logic                   rst,
  input  logic                   move_tick,
  input  logic [9:0]             rnd,
  input  logic [NUM_SLOTS-1:0]   kill,
  output logic [10*NUM_SLOTS-1:0] pos_x,
  output logic [10*NUM_SLOTS-1:0] pos_y,
  output logic [NUM_SLOTS-1:0]   alive,
  output logic                   spawn_pulse,
  output logic [2:0]             spawn_id,
  output logic                   busy
`ifdef DRAGON_SCHED_STATS_EN
  ,
  output logic [15:0]            kill_count
`endif
);

  localparam int CD_W  = $clog2(COOLDOWN + 1);
  localparam int CNT_W = $clog2(NUM_SLOTS + 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t     state_q;
  logic [2:0] idx_q;
  logic       pending_q;
  logic       busy_q;

  logic [9:0]           x_q     [NUM_SLOTS];
  logic [9:0]           x_d     [NUM_SLOTS];
  logic [9:0]           y_q     [NUM_SLOTS];
  logic [9:0]           y_d     [NUM_SLOTS];
  logic [CD_W-1:0]      cd_q    [NUM_SLOTS];
  logic [CD_W-1:0]      cd_d    [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] alive_q;
  logic [NUM_SLOTS-1:0] alive_d;
  logic                 spawn_pulse_q;
  logic [2:0]           spawn_id_q;

  // Shared per-slot datapath: operands of the slot under scan.
  logic [9:0]      cur_x, cur_y, nx, ny, spawn_x, spawn_y;
  logic            cur_alive;
  logic [CD_W-1:0] cur_cd;
  logic [CNT_W-1:0] alive_cnt;
  logic            scan, edge_hit, respawn;

  assign scan = (state_q == S_SCAN);

  always_comb begin
    cur_x     = '0;
    cur_y     = '0;
    cur_alive = 1'b0;
    cur_cd    = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (idx_q == 3'(i)) begin
        cur_x     = x_q[i];
        cur_y     = y_q[i];
        cur_alive = alive_q[i];
        cur_cd    = cd_q[i];
      end
    end
  end

  always_comb begin
    alive_cnt = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      alive_cnt = alive_cnt + CNT_W'(alive_q[i]);
    end
  end

  // 10-bit wrap is intentional: an underflow lands above the board limit and
  // is caught by the >= comparisons as a death.
  assign nx = cur_x - 10'(STEP);
  assign ny = rnd[0] ? (cur_y + 10'(STEP)) : (cur_y - 10'(STEP));
  assign edge_hit = (nx < 10'(MARGIN)) || (nx >= 10'(X_MAX)) ||
                    (ny < 10'(MARGIN)) || (ny >= 10'(Y_MAX));

  assign spawn_x = 10'(SX_BASE) + (rnd % 10'(SX_RANGE));
  assign spawn_y = 10'(SY_BASE) + ({rnd[4:0], rnd[9:5]} % 10'(SY_RANGE));

  // Only the scanned slot can respawn, so at most one respawn per cycle.
  assign respawn = scan && !cur_alive && (cur_cd == '0) &&
                   (alive_cnt < CNT_W'(MAX_ALIVE));

  always_comb begin
    alive_d = alive_q;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      x_d[i]  = x_q[i];
      y_d[i]  = y_q[i];
      cd_d[i] = cd_q[i];
      if (scan && (idx_q == 3'(i))) begin
        if (alive_q[i]) begin
          if (edge_hit) begin
            alive_d[i] = 1'b0;
            cd_d[i]    = CD_W'(COOLDOWN);
          end else begin
            x_d[i] = nx;
            y_d[i] = ny;
          end
        end else if (cd_q[i] != '0) begin
          cd_d[i] = cd_q[i] - CD_W'(1);
        end else if (respawn) begin
          alive_d[i] = 1'b1;
          x_d[i]     = spawn_x;
          y_d[i]     = spawn_y;
        end
      end
      // A hit on a live slot overrides whatever the scan decided and freezes
      // the position; hits on dead slots are ignored entirely.
      if (kill[i] && alive_q[i]) begin
        alive_d[i] = 1'b0;
        cd_d[i]    = CD_W'(COOLDOWN);
        x_d[i]     = x_q[i];
        y_d[i]     = y_q[i];
      end
    end
  end

  // Pass sequencer.
  always_ff @(posedge clk_22) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (move_tick || pending_q) begin
            state_q   <= S_SCAN;
            idx_q     <= '0;
            busy_q    <= 1'b1;
            pending_q <= 1'b0;
          end
        end
        S_SCAN: begin
          if (move_tick) pending_q <= 1'b1;
          if (idx_q == 3'(NUM_SLOTS - 1)) begin
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_q + 3'd1;
          end
        end
        S_DONE: begin
          if (move_tick) pending_q <= 1'b1;
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Slot state and spawn report.
  always_ff @(posedge clk_22) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        x_q[i]  <= '0;
        y_q[i]  <= '0;
        cd_q[i] <= '0;
      end
      alive_q       <= '0;
      spawn_pulse_q <= 1'b0;
      spawn_id_q    <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        x_q[i]  <= x_d[i];
        y_q[i]  <= y_d[i];
        cd_q[i] <= cd_d[i];
      end
      alive_q       <= alive_d;
      spawn_pulse_q <= respawn;
      if (respawn) spawn_id_q <= idx_q;
    end
  end

`ifdef DRAGON_SCHED_STATS_EN
  logic [15:0]      kill_count_q;
  logic [15:0]      kill_count_d;
  logic [CNT_W-1:0] kill_hits;
  logic [16:0]      kill_sum;

  always_comb begin
    kill_hits = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      kill_hits = kill_hits + CNT_W'(kill[i] & alive_q[i]);
    end
    kill_sum     = {1'b0, kill_count_q} + 17'(kill_hits);
    kill_count_d = kill_sum[16] ? 16'hFFFF : kill_sum[15:0];
  end

  always_ff @(posedge clk_22) begin
    if (!rst) kill_count_q <= '0;
    else      kill_count_q <= kill_count_d;
  end

  assign kill_count = kill_count_q;
`endif

  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_pack
      assign pos_x[10*gi +: 10] = x_q[gi];
      assign pos_y[10*gi +: 10] = y_q[gi];
    end
  endgenerate

  assign alive       = alive_q;
  assign spawn_pulse = spawn_pulse_q;
  assign spawn_id    = spawn_id_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_dragon_wave_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for dragon_wave_scheduler (default parameters, NUM_SLOTS=4).
// Expected per-slot results are pushed to a scoreboard queue as each scan
// cycle is driven and popped when the slot's registered outputs appear.
// -----------------------------------------------------------------------------
module tb_dragon_wave_scheduler;
  localparam int N = 4;

  logic clk_22 = 1'b0;
  always #5 clk_22 = ~clk_22;

  logic             rst = 1'b0;
  logic             move_tick = 1'b0;
  logic [9:0]       rnd = '0;
  logic [N-1:0]     kill = '0;
  logic [10*N-1:0]  pos_x, pos_y;
  logic [N-1:0]     alive;
  logic             spawn_pulse;
  logic [2:0]       spawn_id;
  logic             busy;
`ifdef DRAGON_SCHED_STATS_EN
  logic [15:0]      kill_count;
`endif

  dragon_wave_scheduler dut (
    .clk_22     (clk_22),
    .rst        (rst),
    .move_tick  (move_tick),
    .rnd        (rnd),
    .kill       (kill),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .alive      (alive),
    .spawn_pulse(spawn_pulse),
    .spawn_id   (spawn_id),
    .busy       (busy)
`ifdef DRAGON_SCHED_STATS_EN
    ,
    .kill_count (kill_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state of the slots, derived from the behavioural description.
  logic [9:0] m_x     [N];
  logic [9:0] m_y     [N];
  bit         m_alive [N];
  int         m_cd    [N];
  int         m_kc;

  typedef struct {
    int         slot;
    bit         alive;
    logic [9:0] x;
    logic [9:0] y;
    bit         pulse;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_alive[i]);
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_x[i] = '0; m_y[i] = '0; m_alive[i] = 0; m_cd[i] = 0;
    end
    m_kc = 0;
  endtask

  task automatic tick_edge();
    @(posedge clk_22);
    #1;
  endtask

  task automatic check_stats();
`ifdef DRAGON_SCHED_STATS_EN
    check("kill_count", kill_count, m_kc);
`endif
  endtask

  // One full pass. self_start drives the starting tick (otherwise a pending
  // tick must start it); extra_ticks raises move_tick on scans 1..extra_ticks.
  task automatic do_pass(input logic [9:0] r, input int kill_slot,
                         input bit self_start, input int extra_ticks);
    exp_t       e;
    logic [9:0] nx, ny, swz;
    check("idle_busy", busy, 0);
    rnd       = r;
    move_tick = self_start;
    tick_edge();
    move_tick = 1'b0;
    swz = {r[4:0], r[9:5]};
    for (int s = 0; s < N; s++) begin
      check("scan_busy", busy, 1);
      move_tick = (s >= 1 && s <= extra_ticks);
      kill = '0;
      if (s == kill_slot) kill[s] = 1'b1;
      e.slot  = s;
      e.pulse = 0;
      if (m_alive[s]) begin
        if (s == kill_slot) begin
          m_alive[s] = 0; m_cd[s] = 100; m_kc++;
        end else begin
          nx = m_x[s] - 10'd5;
          ny = r[0] ? m_y[s] + 10'd5 : m_y[s] - 10'd5;
          if (nx < 10'd3 || nx >= 10'd640 || ny < 10'd3 || ny >= 10'd480) begin
            m_alive[s] = 0; m_cd[s] = 100;
          end else begin
            m_x[s] = nx; m_y[s] = ny;
          end
        end
      end else if (m_cd[s] > 0) begin
        m_cd[s]--;
      end else if (m_count() < 3) begin
        m_alive[s] = 1;
        m_x[s] = 10'd450 + (r % 10'd200);
        m_y[s] = 10'd160 + (swz % 10'd320);
        e.pulse = 1;
      end
      e.alive = m_alive[s];
      e.x     = m_x[s];
      e.y     = m_y[s];
      sb.push_back(e);
      tick_edge();
      kill = '0;
      e = sb.pop_front();
      check($sformatf("alive%0d", e.slot), alive[e.slot], e.alive);
      check($sformatf("pos_x%0d", e.slot), pos_x[10*e.slot +: 10], e.x);
      check($sformatf("pos_y%0d", e.slot), pos_y[10*e.slot +: 10], e.y);
      check("spawn_pulse", spawn_pulse, e.pulse);
      if (e.pulse) check("spawn_id", spawn_id, e.slot);
    end
    move_tick = 1'b0;
    check("done_busy", busy, 1);
    tick_edge();
    check("post_pulse", spawn_pulse, 0);
    check_stats();
  endtask

  // Kill strobe while the sequencer is idle.
  task automatic kill_idle(input int s);
    kill[s] = 1'b1;
    if (m_alive[s]) begin
      m_alive[s] = 0; m_cd[s] = 100; m_kc++;
    end
    tick_edge();
    kill = '0;
    check($sformatf("idle_kill_alive%0d", s), alive[s], m_alive[s]);
    check($sformatf("idle_kill_x%0d", s), pos_x[10*s +: 10], m_x[s]);
    check("idle_kill_busy", busy, 0);
    check_stats();
  endtask

  initial begin
    model_reset();

    // Reset values
    repeat (3) tick_edge();
    check("rst_alive", alive, 0);
    check("rst_pos_x", pos_x[31:0], 0);
    check("rst_pos_y", pos_y[31:0], 0);
    check("rst_busy", busy, 0);
    check("rst_spawn_pulse", spawn_pulse, 0);
    check("rst_spawn_id", spawn_id, 0);
    check_stats();
    rst = 1'b1;
    tick_edge();
    $display("reset released");

    // T1: first pass spawns 0,1,2 at (450,160); slot 3 capped
    do_pass(10'd0, -1, 1, 0);
    check("t1_alive", alive, 4'b0111);
    check("t1_x0", pos_x[9:0], 450);
    check("t1_y0", pos_y[9:0], 160);
    $display("T1 pass done alive=%b", alive);

    // T2: movement with rnd[0]=1 then 0
    do_pass(10'd1, -1, 1, 0);
    check("t2_y_up", pos_y[9:0], 165);
    do_pass(10'd0, -1, 1, 0);
    check("t2_y_down", pos_y[9:0], 160);
    check("t2_x", pos_x[9:0], 440);
    $display("T2 movement done x0=%0d y0=%0d", pos_x[9:0], pos_y[9:0]);

    // T4: kill slot 1 during its scan; slot 3 then fits under the cap
    do_pass(10'd6, 1, 1, 0);
    check("t4_x1_frozen", pos_x[19:10], 440);
    $display("T4 kill during scan done alive=%b", alive);

    // T5: tick held 3 cycles mid-pass -> exactly one extra pass
    do_pass(10'd3, -1, 1, 3);
    do_pass(10'd2, -1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick_edge();
      check("t5_no_third_pass", busy, 0);
    end
    $display("T5 pending pass done");

    // Kill while idle: dead slot ignored, live slot dies
    kill_idle(1);
    kill_idle(0);
    $display("idle kills done alive=%b", alive);

    // T3 and general traffic: board-edge deaths, cooldowns, cap
    for (int p = 0; p < 230; p++) begin
      logic [9:0] r;
      r = 10'($urandom_range(0, 1023));
      do_pass(r, (p % 29 == 7) ? (p % N) : -1, 1, 0);
      if (p % 41 == 13) kill_idle(p % N);
      if (p % 20 == 0) $display("pass %0d alive=%b", p, alive);
    end

    // T6: reset during scan of slot 2, with a pending tick outstanding
    rnd = 10'd0;
    move_tick = 1'b1;
    tick_edge();
    tick_edge();
    tick_edge();
    move_tick = 1'b0;
    rst = 1'b0;
    tick_edge();
    check("t6_alive", alive, 0);
    check("t6_pos_x", pos_x[31:0], 0);
    check("t6_pos_y", pos_y[31:0], 0);
    check("t6_busy", busy, 0);
    check("t6_spawn_pulse", spawn_pulse, 0);
    check("t6_spawn_id", spawn_id, 0);
    model_reset();
    check_stats();
    rst = 1'b1;
    tick_edge();
    check("t6_idle1", busy, 0);
    tick_edge();
    check("t6_idle2", busy, 0);
    $display("T6 reset mid-pass done");

    // Bottom-edge death: spawn at y=479, then move down
    do_pass(10'd1001, -1, 1, 0);
    check("y_edge_alive", alive, 4'b0111);
    check("y_edge_spawn_y", pos_y[9:0], 479);
    do_pass(10'd1, -1, 1, 0);
    check("y_edge_dead", alive, 4'b1000);
    check("y_edge_frozen_y", pos_y[9:0], 479);
    check("y_edge_s3_y", pos_y[39:30], 192);
    $display("bottom edge done alive=%b", alive);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
